// File: rtl/dma_pkg.sv
// Shared DMA definitions: arbiter FSM states, channel-number type and channel count.
package dma_pkg;

   localparam int unsigned NUM_CH = 4;

   typedef logic [1:0] ch_num_t;

   typedef enum logic [1:0] {
      StIdle,
      StHoldReq,
      StGrant
   } arb_state_e;

endpackage

// File: rtl/dma_dreq_sync.sv
// Multi-flop synchronizer for the raw, asynchronous DREQ lines.
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears every stage
//   din   - raw channel requests
//   dout  - requests after SYNC_STAGES flops
module dma_dreq_sync
   import dma_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] din,
   output logic [NUM_CH-1:0] dout
);

   logic [NUM_CH-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter with CPU hold handshake.
//   CLK, RESET_N     - clock, asynchronous active-low reset
//   DREQ             - raw asynchronous channel requests
//   SW_REQ           - software requests (bypass MASK)
//   MASK             - per-channel DREQ mask
//   DREQ_SENSE_LOW   - DREQ polarity select
//   DACK_SENSE_HIGH  - DACK polarity select
//   ROT_PRIORITY     - rotating (1) or fixed (0) priority
//   CTRL_DISABLE     - blocks new hold requests
//   HLDA             - hold acknowledge from CPU
//   SVC_DONE         - end-of-service pulse
//   HRQ              - hold request to CPU
//   DACK             - channel acknowledges
//   ACT_CH, CH_VALID - granted channel and its valid flag
//   HI_CH            - current highest-priority channel
module dma_priority_arbiter
   import dma_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] DREQ,
   input  logic [3:0] SW_REQ,
   input  logic [3:0] MASK,
   input  logic       DREQ_SENSE_LOW,
   input  logic       DACK_SENSE_HIGH,
   input  logic       ROT_PRIORITY,
   input  logic       CTRL_DISABLE,
   input  logic       HLDA,
   input  logic       SVC_DONE,
   output logic       HRQ,
   output logic [3:0] DACK,
   output logic [1:0] ACT_CH,
   output logic       CH_VALID,
   output logic [1:0] HI_CH
);

   logic [NUM_CH-1:0] dreq_sync;
   logic [NUM_CH-1:0] pending;
   logic              any_pending;
   ch_num_t           winner;

   arb_state_e        state_q, state_d;
   ch_num_t           act_q, act_d;
   ch_num_t           hi_q, hi_d;
   logic              hrq_q;
   logic              ch_valid_q;
   logic [NUM_CH-1:0] dack_act_q;

   dma_dreq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_dreq_sync (
      .clk  (CLK),
      .rst_n(RESET_N),
      .din  (DREQ),
      .dout (dreq_sync)
   );

   assign pending     = ((dreq_sync ^ {NUM_CH{DREQ_SENSE_LOW}}) & ~MASK) | SW_REQ;
   assign any_pending = |pending;

   // Scan from hi_q upward (mod 4); first pending channel wins.
   always_comb begin
      logic found;
      winner = hi_q;
      found  = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (!found && pending[hi_q + ch_num_t'(i)]) begin
            winner = hi_q + ch_num_t'(i);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      hi_d    = hi_q;
      case (state_q)
         StIdle: begin
            if (any_pending && !CTRL_DISABLE) begin
               state_d = StHoldReq;
            end
         end
         StHoldReq: begin
            if (HLDA) begin
               if (any_pending) begin
                  act_d   = winner;
                  state_d = StGrant;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGrant: begin
            // End of service wins over a simultaneous HLDA drop.
            if (SVC_DONE) begin
               state_d = StIdle;
               if (ROT_PRIORITY) begin
                  hi_d = act_q + ch_num_t'(1);
               end
            end else if (!HLDA) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (!ROT_PRIORITY) begin
         hi_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= StIdle;
         act_q      <= '0;
         hi_q       <= '0;
         hrq_q      <= 1'b0;
         ch_valid_q <= 1'b0;
         dack_act_q <= '0;
      end else begin
         state_q    <= state_d;
         act_q      <= act_d;
         hi_q       <= hi_d;
         hrq_q      <= (state_d != StIdle);
         ch_valid_q <= (state_d == StGrant);
         dack_act_q <= (state_d == StGrant) ? (NUM_CH'(1) << act_d) : '0;
      end
   end

   // Acknowledge is held as an active-high one-hot flop; polarity is applied at the pin so
   // reset lands on the inactive level for whatever sense is currently programmed.
   assign DACK     = DACK_SENSE_HIGH ? dack_act_q : ~dack_act_q;
   assign HRQ      = hrq_q;
   assign CH_VALID = ch_valid_q;
   assign ACT_CH   = act_q;
   assign HI_CH    = hi_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [3:0] DREQ, SW_REQ, MASK;
   logic       DREQ_SENSE_LOW, DACK_SENSE_HIGH, ROT_PRIORITY, CTRL_DISABLE;
   logic       HLDA, SVC_DONE;
   logic       HRQ, CH_VALID;
   logic [3:0] DACK;
   logic [1:0] ACT_CH, HI_CH;
   logic       hlda_tie, hlda_drv;

   int n_assert = 0;
   int n_fail   = 0;

   assign HLDA = hlda_tie ? HRQ : hlda_drv;

   always #5 CLK = ~CLK;

   dma_priority_arbiter #(
      .SYNC_STAGES(2)
   ) dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .DREQ           (DREQ),
      .SW_REQ         (SW_REQ),
      .MASK           (MASK),
      .DREQ_SENSE_LOW (DREQ_SENSE_LOW),
      .DACK_SENSE_HIGH(DACK_SENSE_HIGH),
      .ROT_PRIORITY   (ROT_PRIORITY),
      .CTRL_DISABLE   (CTRL_DISABLE),
      .HLDA           (HLDA),
      .SVC_DONE       (SVC_DONE),
      .HRQ            (HRQ),
      .DACK           (DACK),
      .ACT_CH         (ACT_CH),
      .CH_VALID       (CH_VALID),
      .HI_CH          (HI_CH)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_svc();
      SVC_DONE = 1'b1;
      tick();
      SVC_DONE = 1'b0;
   endtask

   task automatic wait_valid(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (CH_VALID === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_hrq(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (HRQ === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; DREQ = '0; SW_REQ = '0; MASK = '0;
      DREQ_SENSE_LOW = 0; DACK_SENSE_HIGH = 0; ROT_PRIORITY = 0; CTRL_DISABLE = 0;
      SVC_DONE = 0; hlda_tie = 0; hlda_drv = 0;
      #3;
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL reset_hrq got=%b exp=0", HRQ); end
      n_assert++; if (CH_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", CH_VALID); end
      n_assert++; if (ACT_CH !== 2'd0) begin n_fail++; $display("FAIL reset_act got=%0d exp=0", ACT_CH); end
      n_assert++; if (HI_CH !== 2'd0) begin n_fail++; $display("FAIL reset_hi got=%0d exp=0", HI_CH); end
      n_assert++; if (DACK !== 4'b1111) begin n_fail++; $display("FAIL reset_dack_low got=%b exp=1111", DACK); end
      DACK_SENSE_HIGH = 1'b1;
      #1;
      n_assert++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL reset_dack_high got=%b exp=0000", DACK); end
      DACK_SENSE_HIGH = 1'b0;
      tick(); tick();
      RESET_N = 1'b1;
      tick();
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL post_reset_hrq got=%b exp=0", HRQ); end
   endtask

   task automatic test_fixed_priority();
      ROT_PRIORITY = 0; hlda_tie = 1; DREQ = 4'b1010;
      tick(); tick();
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL fix_hrq_early got=%b exp=0", HRQ); end
      tick();
      n_assert++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL fix_hrq_latency got=%b exp=1", HRQ); end
      tick();
      n_assert++; if (CH_VALID !== 1'b1) begin n_fail++; $display("FAIL fix_valid got=%b exp=1", CH_VALID); end
      n_assert++; if (ACT_CH !== 2'd1) begin n_fail++; $display("FAIL fix_act got=%0d exp=1", ACT_CH); end
      n_assert++; if (DACK !== 4'b1101) begin n_fail++; $display("FAIL fix_dack got=%b exp=1101", DACK); end
      // Higher-priority channel arrives mid-grant: grant must not move.
      DREQ = 4'b1011;
      repeat (3) tick();
      n_assert++; if (ACT_CH !== 2'd1 || CH_VALID !== 1'b1) begin
         n_fail++; $display("FAIL fix_hold_act got=%0d/%b exp=1/1", ACT_CH, CH_VALID);
      end
      DREQ = 4'b1010;
      repeat (3) tick();
      pulse_svc();
      n_assert++; if (CH_VALID !== 1'b0 || HRQ !== 1'b0) begin
         n_fail++; $display("FAIL fix_idle got valid=%b hrq=%b exp=0/0", CH_VALID, HRQ);
      end
      n_assert++; if (HI_CH !== 2'd0) begin n_fail++; $display("FAIL fix_hi got=%0d exp=0", HI_CH); end
      n_assert++; if (DACK !== 4'b1111) begin n_fail++; $display("FAIL fix_dack_idle got=%b exp=1111", DACK); end
      tick();
      n_assert++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL fix_rehrq got=%b exp=1", HRQ); end
      tick();
      n_assert++; if (ACT_CH !== 2'd1 || CH_VALID !== 1'b1) begin
         n_fail++; $display("FAIL fix_regrant got=%0d/%b exp=1/1", ACT_CH, CH_VALID);
      end
      DREQ = '0;
      repeat (3) tick();
      pulse_svc();
      tick();
   endtask

   task automatic test_rotation();
      bit         to;
      logic [1:0] exp_ch;
      logic [3:0] exp_dack;
      ROT_PRIORITY = 1; hlda_tie = 1; DREQ = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         exp_ch   = 2'(k);
         exp_dack = ~(4'b0001 << k);
         wait_valid(to);
         n_assert++; if (to) begin n_fail++; $display("FAIL rot_timeout got=timeout exp=grant %0d", k); end
         n_assert++; if (ACT_CH !== exp_ch) begin n_fail++; $display("FAIL rot_act got=%0d exp=%0d", ACT_CH, exp_ch); end
         n_assert++; if (DACK !== exp_dack) begin n_fail++; $display("FAIL rot_dack got=%b exp=%b", DACK, exp_dack); end
         if (k == 3) begin
            DREQ = '0;
            repeat (3) tick();
         end
         pulse_svc();
         exp_ch = 2'((k + 1) % 4);
         n_assert++; if (HI_CH !== exp_ch) begin n_fail++; $display("FAIL rot_hi got=%0d exp=%0d", HI_CH, exp_ch); end
      end
      tick();
   endtask

   task automatic test_mask_sw();
      bit to;
      ROT_PRIORITY = 0; hlda_tie = 1; MASK = 4'b1111; DREQ = 4'b1111;
      repeat (6) tick();
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL mask_hrq got=%b exp=0", HRQ); end
      SW_REQ = 4'b0100;
      wait_valid(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL sw_timeout got=timeout exp=grant"); end
      n_assert++; if (ACT_CH !== 2'd2) begin n_fail++; $display("FAIL sw_act got=%0d exp=2", ACT_CH); end
      n_assert++; if (DACK !== 4'b1011) begin n_fail++; $display("FAIL sw_dack got=%b exp=1011", DACK); end
      SW_REQ = '0; DREQ = '0;
      repeat (3) tick();
      MASK = '0;
      pulse_svc();
      tick();
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL sw_clear got=%b exp=0", HRQ); end
   endtask

   task automatic test_polarity();
      bit to;
      hlda_tie = 1; DREQ = 4'b1111;
      repeat (3) tick();
      DREQ_SENSE_LOW = 1;
      tick();
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL pol_idle_hrq got=%b exp=0", HRQ); end
      DACK_SENSE_HIGH = 1; DREQ = 4'b1110;
      wait_valid(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL pol_timeout got=timeout exp=grant"); end
      n_assert++; if (ACT_CH !== 2'd0) begin n_fail++; $display("FAIL pol_act got=%0d exp=0", ACT_CH); end
      n_assert++; if (DACK !== 4'b0001) begin n_fail++; $display("FAIL pol_dack got=%b exp=0001", DACK); end
      DREQ = 4'b1111;
      repeat (3) tick();
      pulse_svc();
      MASK = 4'b1111; DREQ = '0; DREQ_SENSE_LOW = 0;
      repeat (3) tick();
      MASK = '0; DACK_SENSE_HIGH = 0;
      tick();
   endtask

   task automatic test_abort_norequest();
      bit to;
      hlda_tie = 0; hlda_drv = 0; ROT_PRIORITY = 1;
      // Rotate once so HI_CH is nonzero before the abort.
      DREQ = 4'b0001;
      wait_hrq(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL ab_hrq0_timeout got=timeout exp=hrq"); end
      hlda_drv = 1; tick();
      n_assert++; if (ACT_CH !== 2'd0 || CH_VALID !== 1'b1) begin
         n_fail++; $display("FAIL ab_grant0 got=%0d/%b exp=0/1", ACT_CH, CH_VALID);
      end
      DREQ = '0; repeat (3) tick();
      pulse_svc(); hlda_drv = 0;
      n_assert++; if (HI_CH !== 2'd1) begin n_fail++; $display("FAIL ab_hi_rot got=%0d exp=1", HI_CH); end
      tick();
      DREQ = 4'b1000;
      wait_hrq(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL ab_hrq3_timeout got=timeout exp=hrq"); end
      hlda_drv = 1; tick();
      n_assert++; if (ACT_CH !== 2'd3) begin n_fail++; $display("FAIL ab_act3 got=%0d exp=3", ACT_CH); end
      DREQ = '0; repeat (3) tick();
      hlda_drv = 0; tick();
      n_assert++; if (CH_VALID !== 1'b0 || HRQ !== 1'b0) begin
         n_fail++; $display("FAIL ab_idle got valid=%b hrq=%b exp=0/0", CH_VALID, HRQ);
      end
      n_assert++; if (HI_CH !== 2'd1) begin n_fail++; $display("FAIL ab_hi_kept got=%0d exp=1", HI_CH); end
      n_assert++; if (DACK !== 4'b1111) begin n_fail++; $display("FAIL ab_dack got=%b exp=1111", DACK); end
      // Request withdrawn while waiting for HLDA, CTRL_DISABLE raised meanwhile.
      DREQ = 4'b0100;
      wait_hrq(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL nr_hrq_timeout got=timeout exp=hrq"); end
      DREQ = '0; CTRL_DISABLE = 1;
      repeat (3) tick();
      n_assert++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL nr_hold got=%b exp=1", HRQ); end
      hlda_drv = 1; tick();
      n_assert++; if (HRQ !== 1'b0 || CH_VALID !== 1'b0 || DACK !== 4'b1111) begin
         n_fail++; $display("FAIL nr_idle got hrq=%b valid=%b dack=%b exp=0/0/1111", HRQ, CH_VALID, DACK);
      end
      hlda_drv = 0;
      DREQ = 4'b0100; repeat (5) tick();
      n_assert++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL dis_hrq got=%b exp=0", HRQ); end
      DREQ = '0; repeat (3) tick();
      CTRL_DISABLE = 0; tick();
      // SVC_DONE coincident with HLDA drop: rotation still applies.
      DREQ = 4'b0100;
      wait_hrq(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL sv_hrq_timeout got=timeout exp=hrq"); end
      hlda_drv = 1; tick();
      n_assert++; if (ACT_CH !== 2'd2) begin n_fail++; $display("FAIL sv_act got=%0d exp=2", ACT_CH); end
      DREQ = '0; repeat (3) tick();
      hlda_drv = 0; SVC_DONE = 1; tick(); SVC_DONE = 0;
      n_assert++; if (HI_CH !== 2'd3 || CH_VALID !== 1'b0) begin
         n_fail++; $display("FAIL sv_both got hi=%0d valid=%b exp=3/0", HI_CH, CH_VALID);
      end
      tick();
   endtask

   task automatic test_reset_mid_grant();
      bit to;
      hlda_tie = 1; DREQ = 4'b0010;
      wait_valid(to);
      n_assert++; if (to) begin n_fail++; $display("FAIL rg_timeout got=timeout exp=grant"); end
      n_assert++; if (ACT_CH !== 2'd1) begin n_fail++; $display("FAIL rg_act got=%0d exp=1", ACT_CH); end
      #2 RESET_N = 1'b0;
      #1;
      n_assert++; if (DACK !== 4'b1111 || HRQ !== 1'b0 || CH_VALID !== 1'b0) begin
         n_fail++; $display("FAIL rg_drop got dack=%b hrq=%b valid=%b exp=1111/0/0", DACK, HRQ, CH_VALID);
      end
      n_assert++; if (HI_CH !== 2'd0 || ACT_CH !== 2'd0) begin
         n_fail++; $display("FAIL rg_regs got hi=%0d act=%0d exp=0/0", HI_CH, ACT_CH);
      end
      tick();
      RESET_N = 1'b1;
      wait_hrq(to);
      n_assert++; if (to || CH_VALID !== 1'b0) begin
         n_fail++; $display("FAIL rg_fresh got to=%b valid=%b exp=0/0", to, CH_VALID);
      end
      tick();
      n_assert++; if (CH_VALID !== 1'b1 || ACT_CH !== 2'd1) begin
         n_fail++; $display("FAIL rg_regrant got=%b/%0d exp=1/1", CH_VALID, ACT_CH);
      end
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_rotation();
      test_mask_sw();
      test_polarity();
      test_abort_norequest();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: number of DREQ synchronizer flops, legal range 2..3.
REQ-002 The block SHALL have these ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- DREQ  in  4  raw channel requests, asynchronous
- SW_REQ  in  4  software request register bits, active high
- MASK  in  4  mask register; 1 = channel ignored for DREQ
- DREQ_SENSE_LOW  in  1  command bit; 1 = DREQ active low
- DACK_SENSE_HIGH  in  1  command bit; 1 = DACK active high
- ROT_PRIORITY  in  1  command bit; 1 = rotating priority, 0 = fixed
- CTRL_DISABLE  in  1  command bit; 1 = no new grants
- HLDA  in  1  hold acknowledge from CPU
- SVC_DONE  in  1  one-cycle pulse from timing FSM at end of service (S4/EOP)
- HRQ  out  1  hold request to CPU
- DACK  out  4  channel acknowledges, polarity per DACK_SENSE_HIGH
- ACT_CH  out  2  granted channel number
- CH_VALID  out  1  ACT_CH valid; timing FSM may leave SI
- HI_CH  out  2  current highest-priority channel

Function
REQ-003 DREQ SHALL pass through SYNC_STAGES flops per bit before use.
REQ-004 The pending vector SHALL be ((syncDREQ XOR {4{DREQ_SENSE_LOW}}) AND NOT MASK) OR SW_REQ; SW_REQ SHALL ignore MASK.
REQ-005 Priority order SHALL be HI_CH, HI_CH+1, HI_CH+2, HI_CH+3, mod 4; the winner is the first pending channel in that order.
REQ-006 The FSM SHALL have states IDLE, HOLD_REQ and GRANT.
REQ-007 IDLE -> HOLD_REQ on the clock edge where pending != 0 and CTRL_DISABLE = 0.
REQ-008 HRQ SHALL be 1 in HOLD_REQ and GRANT, and 0 in IDLE (registered output).
REQ-009 In HOLD_REQ with HLDA = 1:
- pending != 0: latch the winner into ACT_CH, go to GRANT.
- pending = 0: return to IDLE with no grant.
REQ-010 In HOLD_REQ with HLDA = 0, the block SHALL stay in HOLD_REQ, including when CTRL_DISABLE rises.
REQ-011 In GRANT:
- CH_VALID = 1.
- DACK[ACT_CH] is in its active level; the other three DACK bits are inactive.
- ACT_CH SHALL NOT change, even if a higher-priority request arrives.
REQ-012 GRANT -> IDLE on SVC_DONE = 1. If ROT_PRIORITY = 1, HI_CH <= ACT_CH+1 (mod 4) on that edge.
REQ-013 GRANT -> IDLE on HLDA = 0 without SVC_DONE (abort). HI_CH SHALL be unchanged.
REQ-014 If SVC_DONE and HLDA = 0 occur together, SVC_DONE SHALL take precedence and the rotation SHALL apply.
REQ-015 When ROT_PRIORITY = 0, HI_CH SHALL be held at 0 every cycle.
REQ-016 Grant latency: DREQ edge -> HRQ = SYNC_STAGES+1 cycles; HLDA sampled high -> DACK/CH_VALID = 1 cycle.
REQ-017 After leaving GRANT, the block SHALL spend at least one cycle in IDLE before HRQ reasserts.
REQ-018 DACK, CH_VALID and HRQ SHALL be registered; there SHALL be no combinational path from DREQ or HLDA to any output.

Reset
REQ-019 Asserting RESET_N low SHALL asynchronously force:
- state IDLE, HRQ = 0, CH_VALID = 0, ACT_CH = 0, HI_CH = 0
- synchronizer flops to 0
- DACK to its inactive level per the current DACK_SENSE_HIGH
REQ-020 Reset asserted during GRANT SHALL drop DACK and HRQ immediately; after release, the first grant SHALL occur only via a fresh HOLD_REQ/HLDA sequence.

Structure
REQ-021 The shared DMA package SHALL hold:
- the arbiter state enum (IDLE, HOLD_REQ, GRANT)
- a channel-number type (2 bits)
- constant NUM_CH = 4
REQ-022 A sub-module dma_dreq_sync (SYNC_STAGES-deep, 4-bit synchronizer) SHALL be instantiated for REQ-003; priority resolution and the FSM SHALL be inline.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Fixed priority: DREQ = 4'b1010, MASK = 0, HLDA tied to HRQ -> ACT_CH = 1, DACK = 4'b1101 (active low); after SVC_DONE, HI_CH stays 0 and the next grant is ch1 again.
- Rotation: ROT_PRIORITY = 1, DREQ = 4'b1111, four SVC_DONE cycles -> grants ch0, 1, 2, 3; HI_CH ends at 0.
- Mask vs software request: MASK = 4'b1111, DREQ = 4'b1111 -> HRQ stays 0; then SW_REQ = 4'b0100 -> ACT_CH = 2.
- Polarity: DREQ_SENSE_LOW = 1, DREQ = 4'b1110, DACK_SENSE_HIGH = 1 -> grant ch0 with DACK = 4'b0001.
- Abort and no-request: HLDA dropped in GRANT on ch3 with ROT = 1 -> IDLE, HI_CH unchanged. Separately, DREQ withdrawn before HLDA -> HOLD_REQ returns to IDLE with no DACK.
- Reset mid-GRANT: RESET_N pulsed low -> DACK inactive, HRQ = 0 in the same cycle, HI_CH = 0.
